// File: rtl/piso_shift_tx_pkg.sv
// -----------------------------------------------------------------------------
// piso_shift_tx_pkg
// Shared definitions for the serial bit-stream datapath:
//   - state_e : FSM state encoding (ST_IDLE = 1'b0, ST_SHIFT = 1'b1)
//   - clog2   : constant function used to size bit counters
// -----------------------------------------------------------------------------
package piso_shift_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Ceiling log2; returns 0 for values 0 and 1 so callers can clamp to 1 bit.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    if (value <= 1) begin
      res = 0;
    end else begin
      v = value - 1;
      while (v > 0) begin
        res = res + 1;
        v   = v >>> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/piso_shift_tx.sv
// -----------------------------------------------------------------------------
// piso_shift_tx
// Parallel-in, serial-out transmitter. A SIZE-bit word is accepted through a
// valid/ready handshake and shifted out one bit per clock, with so_valid and
// so_last framing strobes. Back-to-back words are sent with no idle cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   din        in   [SIZE-1:0] parallel word, sampled only on an accepting edge
//   load_valid in   din is valid this cycle
//   load_ready out  word can be accepted this cycle (IDLE, or last shift bit)
//   so         out  serial data (0 whenever so_valid is low)
//   so_valid   out  so carries a payload bit
//   so_last    out  so carries the final bit of the current word
//   busy       out  a word is being shifted
// -----------------------------------------------------------------------------
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] din,
  input  logic            load_valid,
  output logic            load_ready,
  output logic            so,
  output logic            so_valid,
  output logic            so_last,
  output logic            busy
);

  localparam int            CW       = (SIZE <= 1) ? 1 : clog2(SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [SIZE-1:0] s_q;
  logic [SIZE-1:0] s_d;
  logic [SIZE-1:0] load_word;
  logic            load_en;
  logic            shift_en;
  logic            at_last;

  assign at_last = (cnt_q == CNT_LAST);

  // Stage i holds the bit transmitted (SIZE-1-i)-th; stage SIZE-1 drives so.
  // Each shift moves bits toward the output and back-fills stage 0 with zero,
  // so the register is all zeros by the time the final bit has left.
  for (genvar g = 0; g < SIZE; g++) begin : g_stage
    if (MSB_FIRST) begin : g_msb
      assign load_word[g] = din[g];
    end else begin : g_lsb
      assign load_word[g] = din[SIZE-1-g];
    end

    if (g == 0) begin : g_first
      assign s_d[g] = load_en ? load_word[g] : (shift_en ? 1'b0 : s_q[g]);
    end else begin : g_rest
      assign s_d[g] = load_en ? load_word[g] : (shift_en ? s_q[g-1] : s_q[g]);
    end
  end

  // Next-state, counter and shift/load control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_en  = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          load_en = 1'b1;
          cnt_d   = {CW{1'b0}};
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (at_last) begin
          cnt_d = {CW{1'b0}};
          if (load_valid) begin
            // Reload on the last bit keeps the stream gap-free.
            load_en = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            shift_en = 1'b1;
            state_d  = ST_IDLE;
          end
        end else begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State, counter and shift register flops; reset drops any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      s_q     <= {SIZE{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
    end
  end

  assign so         = s_q[SIZE-1];
  assign so_valid   = (state_q == ST_SHIFT);
  assign busy       = (state_q == ST_SHIFT);
  assign so_last    = (state_q == ST_SHIFT) && at_last;
  assign load_ready = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && at_last);

endmodule

// File: tb/tb_piso_shift_tx.sv
module tb_piso_shift_tx;

  logic clk;
  logic rst;

  // SIZE=8, MSB first
  logic [7:0] din_m;
  logic       lv_m, lr_m, so_m, sv_m, sl_m, busy_m;
  // SIZE=8, LSB first
  logic [7:0] din_l;
  logic       lv_l, lr_l, so_l, sv_l, sl_l, busy_l;
  // SIZE=1
  logic [0:0] din_1;
  logic       lv_1, lr_1, so_1, sv_1, sl_1, busy_1;

  int checks = 0;
  int errors = 0;

  piso_shift_tx #(.SIZE(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din_m), .load_valid(lv_m), .load_ready(lr_m),
    .so(so_m), .so_valid(sv_m), .so_last(sl_m), .busy(busy_m));

  piso_shift_tx #(.SIZE(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din_l), .load_valid(lv_l), .load_ready(lr_l),
    .so(so_l), .so_valid(sv_l), .so_last(sl_l), .busy(busy_l));

  piso_shift_tx #(.SIZE(1), .MSB_FIRST(1'b1)) dut_1 (
    .clk(clk), .rst(rst), .din(din_1), .load_valid(lv_1), .load_ready(lr_1),
    .so(so_1), .so_valid(sv_1), .so_last(sl_1), .busy(busy_1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs packed as {so, so_valid, so_last, busy, load_ready}
  task automatic test_reset();
    rst = 1'b1;
    lv_m = 1'b0; lv_l = 1'b0; lv_1 = 1'b0;
    din_m = 8'h00; din_l = 8'h00; din_1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({so_m, sv_m, sl_m, busy_m, lr_m} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_m got=%b exp=%b", {so_m, sv_m, sl_m, busy_m, lr_m}, 5'b00001);
    end
    checks++;
    if ({so_l, sv_l, sl_l, busy_l, lr_l} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_l got=%b exp=%b", {so_l, sv_l, sl_l, busy_l, lr_l}, 5'b00001);
    end
    checks++;
    if ({so_1, sv_1, sl_1, busy_1, lr_1} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_1 got=%b exp=%b", {so_1, sv_1, sl_1, busy_1, lr_1}, 5'b00001);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] stream;
    logic [4:0] exp;
    stream = 8'b0000_1111;
    din_m = 8'h0F;
    lv_m  = 1'b1;
    tick();
    lv_m  = 1'b0;
    din_m = 8'hFF;  // must not disturb the word in flight
    for (int c = 1; c <= 9; c++) begin
      if (c <= 8) exp = {stream[8-c], 1'b1, (c == 8), 1'b1, (c == 8)};
      else        exp = 5'b00001;
      checks++;
      if ({so_m, sv_m, sl_m, busy_m, lr_m} !== exp) begin
        errors++;
        $display("FAIL msb_first cycle=%0d got=%b exp=%b", c, {so_m, sv_m, sl_m, busy_m, lr_m}, exp);
      end
      tick();
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] stream;
    logic [4:0] exp;
    stream = 8'b1111_0000;
    din_l = 8'h0F;
    lv_l  = 1'b1;
    tick();
    lv_l  = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c <= 8) exp = {stream[8-c], 1'b1, (c == 8), 1'b1, (c == 8)};
      else        exp = 5'b00001;
      checks++;
      if ({so_l, sv_l, sl_l, busy_l, lr_l} !== exp) begin
        errors++;
        $display("FAIL lsb_first cycle=%0d got=%b exp=%b", c, {so_l, sv_l, sl_l, busy_l, lr_l}, exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    logic [4:0]  exp;
    stream = 16'b1010_0101_0011_1100;
    din_m = 8'hA5;
    lv_m  = 1'b1;
    tick();
    din_m = 8'h3C;  // held until accepted on the last bit of the first word
    for (int c = 1; c <= 17; c++) begin
      if (c <= 16) exp = {stream[16-c], 1'b1, (c == 8 || c == 16), 1'b1, (c == 8 || c == 16)};
      else         exp = 5'b00001;
      checks++;
      if ({so_m, sv_m, sl_m, busy_m, lr_m} !== exp) begin
        errors++;
        $display("FAIL back_to_back cycle=%0d got=%b exp=%b", c, {so_m, sv_m, sl_m, busy_m, lr_m}, exp);
      end
      if (c >= 9) lv_m = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] stream;
    logic [4:0] exp;
    din_m = 8'hFF;
    lv_m  = 1'b1;
    tick();               // cycle 1
    lv_m = 1'b0;
    tick();               // cycle 2
    tick();               // cycle 3
    rst = 1'b1;
    tick();               // cycle 4
    rst = 1'b0;
    checks++;
    if ({so_m, sv_m, sl_m, busy_m, lr_m} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_mid got=%b exp=%b", {so_m, sv_m, sl_m, busy_m, lr_m}, 5'b00001);
    end
    stream = 8'b1000_0000;
    din_m = 8'h80;
    lv_m  = 1'b1;
    tick();
    lv_m  = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c <= 8) exp = {stream[8-c], 1'b1, (c == 8), 1'b1, (c == 8)};
      else        exp = 5'b00001;
      checks++;
      if ({so_m, sv_m, sl_m, busy_m, lr_m} !== exp) begin
        errors++;
        $display("FAIL after_reset cycle=%0d got=%b exp=%b", c, {so_m, sv_m, sl_m, busy_m, lr_m}, exp);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] bits;
    logic [4:0] exp;
    // reset wins over a load in the same cycle
    rst   = 1'b1;
    lv_m  = 1'b1;
    din_m = 8'hFF;
    tick();
    rst  = 1'b0;
    lv_m = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if ({so_m, sv_m, sl_m, busy_m, lr_m} !== 5'b00001) begin
        errors++;
        $display("FAIL rst_vs_load cycle=%0d got=%b exp=%b", c, {so_m, sv_m, sl_m, busy_m, lr_m}, 5'b00001);
      end
      tick();
    end
    // SIZE=1 continuous stream 1,0,1
    bits  = 3'b101;
    lv_1  = 1'b1;
    din_1 = bits[2];
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c <= 3) exp = {bits[3-c], 1'b1, 1'b1, 1'b1, 1'b1};
      else        exp = 5'b00001;
      checks++;
      if ({so_1, sv_1, sl_1, busy_1, lr_1} !== exp) begin
        errors++;
        $display("FAIL size1 cycle=%0d got=%b exp=%b", c, {so_1, sv_1, sl_1, busy_1, lr_1}, exp);
      end
      if (c <= 2) din_1 = bits[2-c];
      else        lv_1  = 1'b0;
      tick();
    end
  endtask

  task automatic test_loopback();
    logic [7:0] q[$];
    logic [7:0] rx;
    logic [7:0] w;
    int sent;
    int got;
    sent = 0;
    got  = 0;
    rx   = 8'h00;
    lv_m = 1'b0;
    for (int cyc = 0; cyc < 9500 && got < 1000; cyc++) begin
      if (sv_m) begin
        rx = {rx[6:0], so_m};
        if (sl_m) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL loopback_extra got=%h exp=none", rx);
          end else begin
            w = q.pop_front();
            if (rx !== w) begin
              errors++;
              $display("FAIL loopback word=%0d got=%h exp=%h", got, rx, w);
            end
          end
          got++;
        end
      end
      if (lr_m && sent < 1000) begin
        din_m = 8'($urandom);
        lv_m  = 1'b1;
        q.push_back(din_m);
        sent++;
      end else begin
        lv_m = 1'b0;
      end
      tick();
    end
    lv_m = 1'b0;
    checks++;
    if (got != 1000) begin
      errors++;
      $display("FAIL loopback_count got=%0d exp=%0d", got, 1000);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_reset_mid_word();
    test_simultaneous();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
